keyed_demod: RTL and testbench
==============================

Name: keyed_demod

Overview:
- Receive-side counterpart of the DDS modulator. It takes the 14-bit DAC-code sample stream (ASK or FSK keyed carrier) and recovers the 16-bit sequence code that keyed it.
- Sits on the loopback/ADC path next to the generator and shares its mode encoding: 3'b100 ASK, 3'b101 FSK.
- Per bit window it measures peak amplitude (ASK) or counts carrier zero crossings (FSK), slices one bit, and shifts bits in MSB first.

Parameters:
- BIT_CYCLES, 10000: clk_100M cycles per code bit (bit window length).
- HYST, 64: zero-crossing hysteresis around midscale, in LSBs.
- MID, 8192: midscale code of the unsigned offset-binary sample.

Ports:
- clk_100M  input  1  100 MHz system clock.
- rst  input  1  synchronous active-high reset.
- mode  input  3  demod mode, sampled only on an accepted start.
- start  input  1  single-cycle pulse marking a bit-0 boundary.
- sample_in  input  14  unsigned offset-binary sample, one per clock.
- amp_th  input  13  ASK slicing threshold on |sample_in-MID|.
- cross_th  input  16  FSK slicing threshold on rising-crossing count.
- code_out  output  16  recovered code, MSB = first bit received.
- code_valid  output  1  one-cycle pulse when code_out updates.
- busy  output  1  high while a frame is in progress.
- err  output  1  one-cycle pulse: start accepted with unsupported mode.

Behaviour:
- Clock and reset: single clock domain clk_100M; rst is synchronous and active-high.
- Reset: all outputs are 0; FSM returns to IDLE; counters, shift register and arm flag clear. Reset mid-frame aborts the frame with no code_valid pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start with mode 4 or 5 latches mode and goes to RUN, busy=1 next cycle.
  - start with any other mode pulses err for 1 cycle and stays in IDLE (busy stays 0).
- start is ignored while in RUN or DONE.
- RUN, bit windows:
  - Window k (k=0..15) covers samples at cycles 1+k*BIT_CYCLES .. (k+1)*BIT_CYCLES after the start cycle. The start-cycle sample is not used.
  - cyc_cnt counts 0..BIT_CYCLES-1 and wraps; bit_idx counts 0..15.
- Amplitude: mag = |sample_in - MID| using 15-bit signed subtraction, result 13 bits with 8191 max (input 0 gives 8192, clamped to 8191). peak = max(mag) over the window.
- Crossing detector:
  - arm flag sets when sample_in < MID-HYST.
  - When armed and sample_in >= MID+HYST: xcnt increments (saturates at 16'hFFFF) and arm clears.
  - arm persists across bit boundaries and clears only on reset or a new frame start.
- Slicing on the last cycle of each window:
  - bit = (peak >= amp_th) for ASK, (xcnt >= cross_th) for FSK. Both comparisons include the last sample.
  - Shift register updates {sr[14:0],bit}.
  - peak and xcnt restart from the next sample, with no sample lost.
- After bit 15 is sliced, go to DONE:
  - code_out <= shift register; code_valid=1 at cycle 16*BIT_CYCLES+1 after start.
  - busy drops in the same cycle.
  - Next cycle, return to IDLE.
- A start in the cycle code_valid is high is ignored.
- code_out holds its value until the next completed frame.
- Inputs mode, amp_th and cross_th changing mid-frame: mode is latched at start; amp_th and cross_th are used live at each slice.
- Size: 120-400 lines RTL; no multipliers, no RAM.

Test Plan:
- FSK, bench BIT_CYCLES=100: 5 carrier periods per window for bit 1, 2 for bit 0; cross_th=4; code 16'hA5C3 -> single code_valid at cycle 1601 after start, code_out=16'hA5C3, busy high exactly cycles 1..1600.
- ASK: amplitude 4000 for bit 1, constant MID for bit 0; amp_th=2000; code 16'h8001 -> code_out=16'h8001. Then amp_th=4001 on the same stimulus -> 16'h0000.
- Hysteresis: ±50 LSB noise around MID with HYST=64, FSK, cross_th=1 -> code_out=16'h0000. Same with ±100 square wave -> 16'hFFFF.
- Unsupported mode: start with mode=3'b001 -> err pulse of 1 cycle, busy=0, code_valid never asserts, code_out unchanged.
- start pulses at cycles 50 and 1601 during a frame -> both ignored, exactly one code_valid. A start at 1602 -> new frame accepted.
- rst asserted at cycle 800 of a frame -> all outputs 0 next cycle, no code_valid. A fresh start then decodes 16'h3C3C correctly.

Source files
------------

// File: rtl/keyed_demod.sv
// keyed_demod: recovers a 16-bit keyed code from an ASK/FSK DAC-code sample stream
module keyed_demod #(
  parameter int BIT_CYCLES = 10000,
  parameter int HYST = 64,
  parameter int MID = 8192
) (
  input  logic        clk_100M,
  input  logic        rst,
  input  logic [2:0]  mode,
  input  logic        start,
  input  logic [13:0] sample_in,
  input  logic [12:0] amp_th,
  input  logic [15:0] cross_th,
  output logic [15:0] code_out,
  output logic        code_valid,
  output logic        busy,
  output logic        err
);
  localparam int CW = BIT_CYCLES > 1 ? $clog2(BIT_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state, w_next;
  logic          r_fsk, r_arm, r_err;
  logic [CW-1:0] r_cyc;
  logic [3:0]    r_bit;
  logic [12:0]   r_peak;
  logic [15:0]   r_xcnt, r_sr, r_code;
  logic signed [14:0] w_diff;
  logic [14:0]   w_abs;
  logic [12:0]   w_mag, w_peak;
  logic [15:0]   w_xcnt;
  logic          w_ok_mode, w_accept, w_bad, w_last, w_end, w_low, w_high, w_rise, w_bit;
  assign w_ok_mode = mode == 3'b100 || mode == 3'b101;
  assign w_accept  = start && r_state == IDLE && w_ok_mode;
  assign w_bad     = start && r_state == IDLE && !w_ok_mode;
  assign w_last    = r_cyc == CW'(BIT_CYCLES - 1);
  assign w_end     = r_state == RUN && w_last && r_bit == 4'd15;
  assign w_diff    = $signed({1'b0, sample_in}) - $signed(15'(MID));
  assign w_abs     = w_diff[14] ? 15'(-w_diff) : 15'(w_diff);
  assign w_mag     = w_abs > 15'd8191 ? 13'h1FFF : w_abs[12:0];
  assign w_peak    = w_mag > r_peak ? w_mag : r_peak;
  assign w_low     = {1'b0, sample_in} < 15'(MID - HYST);
  assign w_high    = {1'b0, sample_in} >= 15'(MID + HYST);
  assign w_rise    = r_arm && w_high;
  assign w_xcnt    = (w_rise && r_xcnt != 16'hFFFF) ? r_xcnt + 16'd1 : r_xcnt;
  // Slice including the current (last) sample of the window
  assign w_bit     = r_fsk ? (w_xcnt >= cross_th) : (w_peak >= amp_th);
  assign code_out  = r_code;
  // State register
  always_ff @(posedge clk_100M)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  // Next-state logic
  always_comb
    w_next = r_state == IDLE ? (w_accept ? RUN : IDLE) : r_state == RUN ? (w_end ? DONE : RUN) : IDLE;
  // Outputs decoded from state; err is a registered pulse
  always_comb begin
    busy       = r_state == RUN;
    code_valid = r_state == DONE;
    err        = r_err;
  end
  // Window datapath: peak/crossing accumulation, slicing and code capture
  always_ff @(posedge clk_100M)
    if (rst) begin
      r_err  <= 1'b0;
      r_fsk  <= 1'b0;
      r_arm  <= 1'b0;
      r_cyc  <= '0;
      r_bit  <= '0;
      r_peak <= '0;
      r_xcnt <= '0;
      r_sr   <= '0;
      r_code <= '0;
    end else begin
      r_err <= w_bad;
      if (w_accept) begin
        r_fsk  <= mode[0];
        r_arm  <= 1'b0;
        r_cyc  <= '0;
        r_bit  <= '0;
        r_peak <= '0;
        r_xcnt <= '0;
        r_sr   <= '0;
      end else if (r_state == RUN) begin
        r_arm  <= w_low ? 1'b1 : w_rise ? 1'b0 : r_arm;
        r_cyc  <= w_last ? '0 : r_cyc + 1'b1;
        r_peak <= w_last ? '0 : w_peak;
        r_xcnt <= w_last ? '0 : w_xcnt;
        if (w_last) begin
          r_sr  <= {r_sr[14:0], w_bit};
          r_bit <= r_bit + 1'b1;
        end
        if (w_end) r_code <= {r_sr[14:0], w_bit};
      end
    end
endmodule

// File: tb/tb_keyed_demod.sv
// tb_keyed_demod: directed frames for keyed_demod with hand-derived expected codes
module tb_keyed_demod;
  localparam int BC = 100;
  localparam int MID = 8192;
  logic        clk_100M = 1'b0;
  logic        rst, start;
  logic [2:0]  mode;
  logic [13:0] sample_in;
  logic [12:0] amp_th;
  logic [15:0] cross_th;
  logic [15:0] code_out;
  logic        code_valid, busy, err;
  int n_tests = 0;
  int n_fail = 0;

  keyed_demod #(.BIT_CYCLES(BC), .HYST(64), .MID(MID)) dut (
    .clk_100M(clk_100M), .rst(rst), .mode(mode), .start(start), .sample_in(sample_in),
    .amp_th(amp_th), .cross_th(cross_th), .code_out(code_out), .code_valid(code_valid),
    .busy(busy), .err(err)
  );

  always #5 clk_100M = ~clk_100M;

  task automatic tick;
    @(posedge clk_100M);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // kind 0: FSK keyed (5 or 2 periods/window), 1: ASK keyed, 2: +-50 noise, 3: +-100 square
  function automatic logic [13:0] wave(input int kind, input logic [15:0] code, input int c);
    int k, p, per, v;
    logic b;
    k = (c - 1) / BC;
    p = (c - 1) % BC;
    b = code[15 - k];
    per = b ? 20 : 50;
    case (kind)
      0: v = (p % per) < per / 2 ? MID - 1000 : MID + 1000;
      1: v = b ? (p % 2 == 1 ? MID + 4000 : MID - 4000) : MID;
      2: v = p % 2 == 1 ? MID + 50 : MID - 50;
      default: v = (p % 10) < 5 ? MID - 100 : MID + 100;
    endcase
    return 14'(v);
  endfunction

  task automatic frame(input logic [2:0] m, input logic [15:0] code, input int kind,
                       input logic [15:0] exp, input int rst_at, input bit stray);
    int bad, nv;
    bad = 0;
    nv = 0;
    mode = m;
    start = 1'b1;
    tick;
    start = 1'b0;
    mode = 3'b001;
    for (int c = 1; c <= 16 * BC; c++) begin
      if (busy !== 1'b1) bad++;
      if (code_valid !== 1'b0) nv++;
      sample_in = wave(kind, code, c);
      start = stray && c == 50;
      rst = c == rst_at;
      tick;
      start = 1'b0;
      if (c == rst_at) begin
        rst = 1'b0;
        check("rst_code_out", 32'(code_out), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_valid", 32'(code_valid), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        nv = 0;
        for (int i = 0; i < 17 * BC; i++) begin
          if (code_valid !== 1'b0 || busy !== 1'b0) nv++;
          tick;
        end
        check("rst_no_valid", 32'(nv), 32'h0);
        return;
      end
    end
    check("busy_window", 32'(bad), 32'h0);
    check("no_early_valid", 32'(nv), 32'h0);
    check("valid_at_end", 32'(code_valid), 32'h1);
    check("busy_at_end", 32'(busy), 32'h0);
    check("code_out", 32'(code_out), 32'(exp));
    start = stray;
    tick;
    start = 1'b0;
    check("valid_one_cycle", 32'(code_valid), 32'h0);
    check("busy_after", 32'(busy), 32'h0);
  endtask

  initial begin
    int nv;
    rst = 1'b1;
    start = 1'b0;
    mode = 3'b000;
    sample_in = 14'(MID);
    amp_th = 13'd2000;
    cross_th = 16'd4;
    repeat (3) tick;
    check("reset_code_out", 32'(code_out), 32'h0);
    check("reset_valid", 32'(code_valid), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_err", 32'(err), 32'h0);
    rst = 1'b0;
    tick;
    frame(3'b101, 16'hA5C3, 0, 16'hA5C3, 0, 1'b0);
    frame(3'b100, 16'h8001, 1, 16'h8001, 0, 1'b0);
    amp_th = 13'd4001;
    frame(3'b100, 16'h8001, 1, 16'h0000, 0, 1'b0);
    cross_th = 16'd1;
    frame(3'b101, 16'h0000, 3, 16'hFFFF, 0, 1'b0);
    mode = 3'b001;
    start = 1'b1;
    tick;
    start = 1'b0;
    check("err_pulse", 32'(err), 32'h1);
    check("err_busy", 32'(busy), 32'h0);
    tick;
    check("err_one_cycle", 32'(err), 32'h0);
    nv = 0;
    for (int i = 0; i < 300; i++) begin
      if (code_valid !== 1'b0 || busy !== 1'b0) nv++;
      tick;
    end
    check("err_no_frame", 32'(nv), 32'h0);
    check("err_code_held", 32'(code_out), 32'hFFFF);
    frame(3'b101, 16'h0000, 2, 16'h0000, 0, 1'b0);
    cross_th = 16'd4;
    amp_th = 13'd2000;
    frame(3'b101, 16'hA5C3, 0, 16'hA5C3, 0, 1'b1);
    frame(3'b100, 16'h8001, 1, 16'h8001, 0, 1'b0);
    frame(3'b101, 16'h3C3C, 0, 16'h3C3C, 800, 1'b0);
    frame(3'b101, 16'h3C3C, 0, 16'h3C3C, 0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
